// File: rtl/buzz_pkg.sv
// Shared definitions for the beep scheduler.
// - FSM state encoding (IDLE / ON / OFF)
// - Requester count and counter widths
// - Fixed-priority helper: lowest set index of a request vector
package buzz_pkg;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int NUM_W  = 4;   // beeps per pattern, max 15
    localparam int MS_W   = 16;  // clk cycles within one ms
    localparam int PER_W  = 10;  // ms within one on/off period

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // Index 0 wins; scanning downward lets the lowest index overwrite.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/buzz_sched_if.sv
// Client-side bus of the beep scheduler.
// master: the clients (drive req / req_num / stop, observe status)
// slave : the scheduler (drives en_buz / busy / gnt_id / done / pend)
interface buzz_sched_if;
    import buzz_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [NUM_W*N_REQ-1:0] req_num;
    logic                   stop;
    logic                   en_buz;
    logic                   busy;
    logic [ID_W-1:0]        gnt_id;
    logic                   done;
    logic [N_REQ-1:0]       pend;

    modport master (
        output req, req_num, stop,
        input  en_buz, busy, gnt_id, done, pend
    );

    modport slave (
        input  req, req_num, stop,
        output en_buz, busy, gnt_id, done, pend
    );

endinterface

// File: rtl/buzz_ms_tick.sv
// Millisecond tick divider.
// Ports: clk, rst (sync, active-high), clr (sync restart of the divider),
//        tick (high for one cycle every TICK_DIV cycles).
// clr is asserted at grant so the first ms of a pattern is a full ms.
module buzz_ms_tick
    import buzz_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [MS_W-1:0] cnt_reg;

    assign tick = (cnt_reg == MS_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + MS_W'(1);
        end
    end

endmodule

// File: rtl/buzz_sched.sv
// Beep scheduler in front of the buzzer tone generator.
// Ports: clk, rst (sync, active-high), bus (buzz_sched_if.slave):
//   req/req_num/stop from clients; en_buz to the tone generator;
//   busy/gnt_id/done/pend as status.
// Latches requests into pend, grants the lowest pending index from IDLE,
// and plays req_num[g] beeps of ON_MS on / OFF_MS off each.
module buzz_sched
    import buzz_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int ON_MS    = 100,
    parameter int OFF_MS   = 100
) (
    input  logic         clk,
    input  logic         rst,
    buzz_sched_if.slave  bus
);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   pend_reg, pend_next;
    logic [NUM_W-1:0]   beeps_reg, beeps_next;
    logic [PER_W-1:0]   per_reg, per_next;
    logic [ID_W-1:0]    gnt_reg, gnt_next;
    logic               en_reg, en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [N_REQ-1:0]   grant_mask;
    logic [N_REQ-1:0]   new_req;
    logic [NUM_W-1:0]   num_arr [N_REQ];
    logic               ms_clr;
    logic               ms_tick;
    logic [ID_W-1:0]    g_sel;

    // A request with a zero count is ignored entirely.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign num_arr[gi] = bus.req_num[NUM_W*gi +: NUM_W];
            assign new_req[gi] = bus.req[gi] && (num_arr[gi] != '0);
        end
    endgenerate

    assign g_sel = lowest_set(pend_reg);

    buzz_ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (ms_clr),
        .tick (ms_tick)
    );

    always_comb begin
        state_next = state_reg;
        beeps_next = beeps_reg;
        per_next   = per_reg;
        gnt_next   = gnt_reg;
        en_next    = en_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        ms_clr     = 1'b0;
        grant_mask = '0;

        case (state_reg)
            ST_IDLE: begin
                if (pend_reg != '0) begin
                    gnt_next          = g_sel;
                    busy_next         = 1'b1;
                    en_next           = 1'b1;
                    beeps_next        = num_arr[g_sel];
                    per_next          = '0;
                    ms_clr            = 1'b1;
                    grant_mask[g_sel] = 1'b1;
                    state_next        = ST_ON;
                end
            end
            ST_ON: begin
                if (ms_tick) begin
                    if (per_reg == PER_W'(ON_MS - 1)) begin
                        per_next   = '0;
                        en_next    = 1'b0;
                        state_next = ST_OFF;
                    end else begin
                        per_next = per_reg + PER_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (ms_tick) begin
                    if (per_reg == PER_W'(OFF_MS - 1)) begin
                        per_next   = '0;
                        beeps_next = beeps_reg - NUM_W'(1);
                        // A count re-sampled as zero at grant plays one beep
                        // rather than wrapping to 15.
                        if (beeps_reg > NUM_W'(1)) begin
                            en_next    = 1'b1;
                            state_next = ST_ON;
                        end else begin
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        per_next = per_reg + PER_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Grant clears first, so a re-request in the grant cycle survives.
        pend_next = (pend_reg & ~grant_mask) | new_req;

        if (bus.stop) begin
            state_next = ST_IDLE;
            en_next    = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            pend_next  = '0;
            ms_clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pend_reg  <= '0;
            beeps_reg <= '0;
            per_reg   <= '0;
            gnt_reg   <= '0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            beeps_reg <= beeps_next;
            per_reg   <= per_next;
            gnt_reg   <= gnt_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.en_buz = en_reg;
    assign bus.busy   = busy_reg;
    assign bus.gnt_id = gnt_reg;
    assign bus.done   = done_reg;
    assign bus.pend   = pend_reg;

endmodule

// File: tb/tb_buzz_sched.sv
// Testbench for buzz_sched with TICK_DIV=4, ON_MS=2, OFF_MS=1.
// A pattern-level model predicts outputs from "cycles since grant";
// a compare process checks it every negedge; directed literal checks
// pin the model at the edges called out by the test plan.
module tb_buzz_sched;

    localparam int TD   = 4;
    localparam int ONM  = 2;
    localparam int OFFM = 1;
    localparam int ONC  = ONM * TD;            // 8 cycles on
    localparam int PER  = (ONM + OFFM) * TD;   // 12 cycles per beep

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   cmp_en;

    buzz_sched_if bus ();

    buzz_sched #(.TICK_DIV(TD), .ON_MS(ONM), .OFF_MS(OFFM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0] pend;
        bit         active;
        int         k;      // edges since grant
        int         n;      // beeps of current pattern
        int         g;
        bit         done;
        bit         en;
    } model_t;

    model_t m;

    function automatic model_t step_model(model_t s, logic r, logic st,
                                          logic [3:0] rq, logic [15:0] num);
        model_t o;
        logic [3:0] nr;
        int g;
        o = s;
        o.done = 1'b0;
        for (int i = 0; i < 4; i++) nr[i] = rq[i] && (num[4*i +: 4] != 4'd0);
        if (r) begin
            o = '{pend: 4'd0, active: 1'b0, k: 0, n: 0, g: 0, done: 1'b0, en: 1'b0};
        end else if (st) begin
            o.pend   = 4'd0;
            o.active = 1'b0;
        end else begin
            if (s.active) begin
                o.k = s.k + 1;
                if (o.k >= s.n * PER) begin
                    o.active = 1'b0;
                    o.done   = 1'b1;
                end
            end else if (s.pend != 4'd0) begin
                g = 0;
                while (!s.pend[g]) g++;
                o.active  = 1'b1;
                o.k       = 0;
                o.g       = g;
                o.n       = int'(num[4*g +: 4]);
                o.pend[g] = 1'b0;
            end
            o.pend = o.pend | nr;
        end
        o.en = o.active && ((o.k % PER) < ONC);
        return o;
    endfunction

    always @(posedge clk) begin
        m <= step_model(m, rst, bus.stop, bus.req, bus.req_num);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp en_buz", int'(bus.en_buz), int'(m.en));
            chk("cmp busy",   int'(bus.busy),   int'(m.active));
            chk("cmp done",   int'(bus.done),   int'(m.done));
            chk("cmp pend",   int'(bus.pend),   int'(m.pend));
            if (m.active) chk("cmp gnt_id", int'(bus.gnt_id), m.g);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_num(input int i, input logic [3:0] v);
        bus.req_num[4*i +: 4] = v;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cmp_en   = 1'b0;
        rst      = 1'b1;
        bus.req     = '0;
        bus.req_num = '0;
        bus.stop    = 1'b0;
        step(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset en_buz", int'(bus.en_buz), 0);
        chk("reset busy",   int'(bus.busy),   0);
        chk("reset pend",   int'(bus.pend),   0);
        chk("reset done",   int'(bus.done),   0);
        step(1);

        // T1: two beeps from requester 1
        bus.req = 4'b0010; set_num(1, 4'd2);
        step(1);                                   // edge 0
        chk("t1 pend latch", int'(bus.pend), 2);
        bus.req = '0;
        step(1);                                   // edge 1
        chk("t1 grant busy", int'(bus.busy), 1);
        chk("t1 grant id",   int'(bus.gnt_id), 1);
        chk("t1 grant en",   int'(bus.en_buz), 1);
        step(7);                                   // edge 8
        chk("t1 on last", int'(bus.en_buz), 1);
        step(1);                                   // edge 9
        chk("t1 off first", int'(bus.en_buz), 0);
        step(4);                                   // edge 13
        chk("t1 on2 first", int'(bus.en_buz), 1);
        step(11);                                  // edge 24
        chk("t1 busy before done", int'(bus.busy), 1);
        step(1);                                   // edge 25
        chk("t1 done", int'(bus.done), 1);
        chk("t1 busy end", int'(bus.busy), 0);
        step(1);
        chk("t1 done pulse", int'(bus.done), 0);
        $display("txn t1: req1 x2 beeps");

        // T2: simultaneous req1 (1 beep) and req3 (3 beeps)
        bus.req = 4'b1010; set_num(1, 4'd1); set_num(3, 4'd3);
        step(1);
        chk("t2 pend both", int'(bus.pend), 10);
        bus.req = '0;
        step(1);
        chk("t2 first id", int'(bus.gnt_id), 1);
        step(12);
        chk("t2 done1", int'(bus.done), 1);
        chk("t2 pend3 held", int'(bus.pend), 8);
        step(1);
        chk("t2 second id", int'(bus.gnt_id), 3);
        chk("t2 second busy", int'(bus.busy), 1);
        step(36);
        chk("t2 done3", int'(bus.done), 1);
        step(1);
        $display("txn t2: req1 then req3 x3");

        // T3: no preemption
        bus.req = 4'b0100; set_num(2, 4'd1);
        step(1);
        bus.req = '0;
        step(1);                                   // grant g
        step(2);
        bus.req = 4'b0001; set_num(0, 4'd1);
        step(1);                                   // g+3
        bus.req = '0;
        chk("t3 no preempt id", int'(bus.gnt_id), 2);
        chk("t3 pend0", int'(bus.pend), 1);
        step(9);                                   // g+12
        chk("t3 done2", int'(bus.done), 1);
        step(1);
        chk("t3 then id0", int'(bus.gnt_id), 0);
        step(12);
        chk("t3 done0", int'(bus.done), 1);
        step(1);
        $display("txn t3: no preemption");

        // T4: stop in the middle of ON with pend=0100
        bus.req = 4'b0010; set_num(1, 4'd1);
        step(1);
        bus.req = '0;
        step(1);                                   // grant g
        bus.req = 4'b0100; set_num(2, 4'd1);
        step(1);
        bus.req = '0;
        step(2);                                   // g+3
        chk("t4 pend before stop", int'(bus.pend), 4);
        bus.stop = 1'b1;
        step(1);                                   // g+4: 5th ON cycle
        bus.stop = 1'b0;
        chk("t4 stop en",   int'(bus.en_buz), 0);
        chk("t4 stop busy", int'(bus.busy), 0);
        chk("t4 stop pend", int'(bus.pend), 0);
        chk("t4 stop done", int'(bus.done), 0);
        step(3);
        chk("t4 stays idle", int'(bus.busy), 0);
        bus.req = 4'b0001; set_num(0, 4'd1);
        step(1);
        bus.req = '0;
        step(1);
        chk("t4 regrant", int'(bus.gnt_id), 0);
        chk("t4 regrant busy", int'(bus.busy), 1);
        step(13);
        $display("txn t4: stop mid-on");

        // T5: zero count ignored
        bus.req = 4'b0100; set_num(2, 4'd0);
        step(1);
        bus.req = '0;
        chk("t5 zero pend", int'(bus.pend), 0);
        step(1);
        chk("t5 zero busy", int'(bus.busy), 0);
        $display("txn t5: zero count ignored");

        // T6: stop dominates req
        bus.stop = 1'b1; bus.req = 4'b0001; set_num(0, 4'd1);
        step(1);
        bus.stop = 1'b0; bus.req = '0;
        chk("t6 stop pend", int'(bus.pend), 0);
        step(1);
        chk("t6 no grant", int'(bus.busy), 0);
        $display("txn t6: stop beats req");

        // T7: reset mid-OFF
        bus.req = 4'b0001; set_num(0, 4'd2);
        step(1);
        bus.req = '0;
        step(1);                                   // grant g
        step(9);                                   // g+9, in OFF
        chk("t7 in off", int'(bus.en_buz), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t7 rst en",   int'(bus.en_buz), 0);
        chk("t7 rst busy", int'(bus.busy), 0);
        chk("t7 rst pend", int'(bus.pend), 0);
        chk("t7 rst done", int'(bus.done), 0);
        step(1);
        bus.req = 4'b0010; set_num(1, 4'd1);
        step(1);
        bus.req = '0;
        step(1);
        chk("t7 post grant id", int'(bus.gnt_id), 1);
        chk("t7 post grant en", int'(bus.en_buz), 1);
        step(12);
        chk("t7 post done", int'(bus.done), 1);
        step(2);
        $display("txn t7: reset mid-off");

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buzz_sched.md
Name: buzz_sched

Overview:
- Beep scheduler sitting in front of the 1.25 kHz buzzer tone generator; drives that generator's `en_buz` input.
- Accepts beep requests from up to 4 clients (key click, alarm, status, etc.) and arbitrates them with fixed priority.
- Plays each granted request as N on/off beeps with millisecond-timed on and off periods.
- Reports busy/grant/done so clients can chain or observe.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 for this revision; index 0 is highest priority).
- TICK_DIV, 50000, clk cycles per 1 ms time unit (50 MHz clk).
- ON_MS, 100, beep-on duration in ms (1..1023).
- OFF_MS, 100, inter-beep silence in ms (1..1023); also applied after the last beep as a guard gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- req  in  4  per-requester request strobe; sampled every cycle; level or pulse both accepted.
- req_num  in  16  flattened beep counts; bits [4i+3:4i] belong to requester i.
- stop  in  1  abort: cancel the current pattern and clear all pending requests.
- en_buz  out  1  tone enable to the buzzer generator.
- busy  out  1  a pattern is playing.
- gnt_id  out  2  index of the requester being served; valid only while busy=1.
- done  out  1  one-cycle pulse when a pattern completes normally (not on stop).
- pend  out  4  latched pending-request bits.

Behaviour:
- Reset (rst=1 at a clk edge): en_buz=0, busy=0, gnt_id=0, done=0, pend=0, FSM=IDLE, all counters=0.
- Request latching:
  - At each edge, pend[i] is set if req[i]=1 and the req_num slice for i is nonzero.
  - A requester with req_num=0 is ignored.
  - A repeated request from an already-pending requester is absorbed (a single pending bit).
  - Its count is re-sampled at grant, not at latch.
- FSM states are IDLE, ON, OFF.
- IDLE:
  - If pend≠0, pick the lowest set index g. At that edge, set busy=1, gnt_id=g, en_buz=1, clear pend[g], capture beeps=req_num slice g, and restart the ms and period counters. Next state is ON.
  - The grant occurs one edge after latching, so latency from a req edge to en_buz=1 is 2 edges.
  - A request latched while busy becomes eligible in the first IDLE cycle.
- ON: lasts exactly ON_MS*TICK_DIV cycles with en_buz=1, then goes to OFF with en_buz=0.
- OFF:
  - Lasts exactly OFF_MS*TICK_DIV cycles with en_buz=0.
  - When it expires, decrement beeps. If the remaining count is ≠0, return to ON with en_buz=1.
  - Otherwise set busy=0 and done=1 for one cycle, and go to IDLE.
  - A pending request may be granted at the next edge, giving back-to-back patterns with exactly one IDLE cycle between them.
- Total busy time per pattern = beeps*(ON_MS+OFF_MS)*TICK_DIV cycles.
- No preemption: a higher-priority request arriving mid-pattern waits in pend.
- Re-request by the client currently being served sets its pend bit, so the pattern plays again afterwards.
- stop:
  - At the edge where stop=1: en_buz=0, busy=0, done=0, pend=0, FSM=IDLE.
  - stop dominates any req in the same cycle; such a req is dropped.
  - Has no effect in IDLE other than clearing pend.
- Widths:
  - ms counter is 16 bits, free of wrap (TICK_DIV ≤ 65535).
  - Period counter is 10 bits.
  - beeps is 4 bits (max 15 beeps).
- rst mid-pattern: same as the reset values above; en_buz drops at that edge.
- The tone generator's own free-running phase is not synchronised; en_buz gating only.

Decomposition:
- Shared package/header `buzz_pkg`: FSM state encodings (IDLE/ON/OFF), counter width constants, N_REQ.
- One natural sub-module: `buzz_ms_tick`, a TICK_DIV divider with sync clear.
  - Outputs a 1-cycle ms tick.
  - Cleared at grant so periods are exact.
- The FSM, arbiter and period counter stay in `buzz_sched`.

Test Plan (TICK_DIV=4, ON_MS=2, OFF_MS=1 → on=8 cycles, off=4 cycles):
- req=0010, num1=2 pulsed at edge 0 → pend[1]=1 at edge 0. Grant at edge 1: busy=1, gnt_id=1, en_buz=1. en_buz pattern is 8 high / 4 low / 8 high / 4 low. busy=0 and done=1 at edge 25.
- req=1010 same cycle, num1=1, num3=3 → requester 1 served first (12 cycles). pend[3] held. Requester 3 granted 1 cycle after done and plays 3 beeps (36 busy cycles).
- Mid-pattern req[0] with num0=1 during requester 2's first ON → no preemption. gnt_id stays 2 until its done; then gnt_id=0.
- stop=1 at 5th cycle of ON while pend=0100 → at that edge en_buz=0, busy=0, pend=0, no done pulse. A subsequent req=0001 is granted normally.
- req[2]=1 with num2=0 → pend stays 0, busy stays 0.
- Simultaneous stop=1 and req=0001 → pend=0, no grant.
- rst=1 for 1 cycle mid-OFF → all outputs 0 at that edge. Next req behaves as after power-up.
